// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master : datapath side; drives run and the hazard-detection taps,
//            receives the PC / pipeline-register controls.
//   slave  : controller side (pipe_hazard_ctrl).
// Signals:
//   run              pipeline enable (1 = execute, 0 = drain then halt)
//   id_rs, id_rt     IF/ID source register fields [25:21], [20:16]
//   id_uses_rt       ID-stage instruction reads rt
//   ex_mem_read      ID/EX MemRead
//   ex_rt            ID/EX load destination [20:16]
//   mem_branch_taken EX/MEM Branch & Zflag
//   pc_we, pc_src    PC load enable, PC mux select (1 = branch target)
//   ifid_we          IF/ID load enable
//   ifid_flush       IF/ID loads a bubble
//   idex_flush       ID/EX control bits load zero
//   exmem_flush      EX/MEM control bits load zero
interface pipe_hazard_ctrl_if;
  logic       run;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       pc_we;
  logic       pc_src;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;

  modport master (
    output run, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken,
    input  pc_we, pc_src, ifid_we, ifid_flush, idex_flush, exmem_flush
  );

  modport slave (
    input  run, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken,
    output pc_we, pc_src, ifid_we, ifid_flush, idex_flush, exmem_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// run/drain/halt sequencer for a classic 5-stage pipeline.
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   hz         hazard-control bundle (slave side)
//   state      current FSM state
//   halted     high only in HALTED
//   stall_cnt  load-use stall cycles, saturating
//   flush_cnt  taken-branch flush events, saturating
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | out of reset, pipeline frozen, waits for run
// RUN     | normal execution; stalls/flushes serviced
// DRAIN   | injecting bubbles into IF/ID for DRAIN_LEN cycles
// HALTED  | pipeline empty and frozen, waits for run to resume
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz,
  output logic [1:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DW = $clog2(DRAIN_LEN + 1);
  localparam logic [DW-1:0] DRAIN_RELOAD = DW'(DRAIN_LEN);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic active;
  logic taken;
  logic stall;

  always_comb begin
    hazard = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
             ((hz.ex_rt == hz.id_rs) ||
              (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    active = (state_q == S_RUN) || (state_q == S_DRAIN);
    // taken has priority: a branch flush also squashes the stalled instruction
    taken  = active && hz.mem_branch_taken;
    stall  = active && hazard && !taken;
  end

  // Mealy control outputs; held at IDLE values while rst is asserted
  always_comb begin
    hz.pc_we       = 1'b0;
    hz.pc_src      = 1'b0;
    hz.ifid_we     = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    if (!rst && active) begin
      if (taken) begin
        hz.pc_we       = 1'b1;
        hz.pc_src      = 1'b1;
        hz.ifid_we     = 1'b1;
        hz.ifid_flush  = 1'b1;
        hz.idex_flush  = 1'b1;
        hz.exmem_flush = 1'b1;
      end else if (stall) begin
        hz.idex_flush  = 1'b1;
      end else if (state_q == S_RUN) begin
        hz.pc_we       = 1'b1;
        hz.ifid_we     = 1'b1;
      end else begin
        // drain: PC frozen, bubbles pushed into IF/ID
        hz.ifid_we     = 1'b1;
        hz.ifid_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hz.run) state_d = S_RUN;
      end
      S_RUN: begin
        if (!hz.run) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_RELOAD;
        end
      end
      S_DRAIN: begin
        // run is ignored here: a started drain always completes
        if (taken) begin
          drain_cnt_d = DRAIN_RELOAD;
        end else if (stall) begin
          drain_cnt_d = drain_cnt_q;
        end else if (drain_cnt_q <= DW'(1)) begin
          state_d     = S_HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: begin
        if (hz.run) state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (taken && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == S_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (CNT_W=2 so saturation is reachable).
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 2;

  // control vector order: {pc_we, pc_src, ifid_we, ifid_flush, idex_flush, exmem_flush}
  localparam logic [5:0] C_ZERO  = 6'b000000;
  localparam logic [5:0] C_RUN   = 6'b101000;
  localparam logic [5:0] C_TAKEN = 6'b111111;
  localparam logic [5:0] C_STALL = 6'b000010;
  localparam logic [5:0] C_DRAIN = 6'b001100;

  logic             clk;
  logic             rst;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks;
  int n_errors;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (bus.slave),
    .state     (state),
    .halted    (halted),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {26'd0, bus.pc_we, bus.pc_src, bus.ifid_we,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic mr, input logic [4:0] ert,
                     input logic br);
    bus.run              = r;
    bus.id_rs            = rs;
    bus.id_rt            = rt;
    bus.id_uses_rt       = ur;
    bus.ex_mem_read      = mr;
    bus.ex_rt            = ert;
    bus.mem_branch_taken = br;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_ctl", ctl(), 32'(C_ZERO));
    // run and a branch during reset are ignored
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("rst_taken_ctl", ctl(), 32'(C_ZERO));
    step();
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_flush", 32'(flush_cnt), 32'd0);

    rst = 1'b0;
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("idle_ctl", ctl(), 32'(C_ZERO));
    step();
    chk("run_state", 32'(state), 32'd1);
    chk("run_ctl", ctl(), 32'(C_RUN));

    // load-use on rs
    drv(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    chk("haz_rs_ctl", ctl(), 32'(C_STALL));
    step();
    chk("haz_rs_cnt", 32'(stall_cnt), 32'd1);
    drv(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0);
    chk("haz_release_ctl", ctl(), 32'(C_RUN));
    step();
    chk("haz_once_cnt", 32'(stall_cnt), 32'd1);

    // r0 destination never stalls
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("haz_r0_ctl", ctl(), 32'(C_RUN));
    step();
    chk("haz_r0_cnt", 32'(stall_cnt), 32'd1);

    // rt match only counts when rt is read
    drv(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
    chk("haz_rt_unused", ctl(), 32'(C_RUN));
    drv(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    chk("haz_rt_used", ctl(), 32'(C_STALL));
    step();
    chk("haz_rt_cnt", 32'(stall_cnt), 32'd2);

    // taken beats hazard
    drv(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    chk("taken_haz_ctl", ctl(), 32'(C_TAKEN));
    step();
    chk("taken_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("taken_stall_cnt", 32'(stall_cnt), 32'd2);

    // saturation of stall_cnt at 3
    drv(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step();
    chk("sat_3", 32'(stall_cnt), 32'd3);
    step();
    chk("sat_hold", 32'(stall_cnt), 32'd3);

    // run=0 in RUN: normal outputs this cycle, DRAIN next
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("run_off_ctl", ctl(), 32'(C_RUN));
    step();
    chk("drain_enter", 32'(state), 32'd2);
    chk("drain1_ctl", ctl(), 32'(C_DRAIN));
    step();
    chk("drain1_state", 32'(state), 32'd2);
    drv(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    chk("drain_haz_ctl", ctl(), 32'(C_STALL));
    step();
    chk("drain_haz_state", 32'(state), 32'd2);
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("drain3_ctl", ctl(), 32'(C_DRAIN));
    step();
    chk("drain3_state", 32'(state), 32'd2);
    step();
    chk("drain4_state", 32'(state), 32'd2);
    chk("drain5_ctl", ctl(), 32'(C_DRAIN));
    step();
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_ctl", ctl(), 32'(C_ZERO));
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("halt_taken_ctl", ctl(), 32'(C_ZERO));
    step();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_flush", 32'(flush_cnt), 32'd1);
    chk("resume_halted", 32'(halted), 32'd0);

    // taken mid-drain reloads the drain counter
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    step();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("drain_taken_ctl", ctl(), 32'(C_TAKEN));
    step();
    chk("drain_taken_flush", 32'(flush_cnt), 32'd2);
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    step();
    chk("reload_state", 32'(state), 32'd2);
    step();
    chk("reload_halt", 32'(state), 32'd3);

    // reset mid-drain
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    chk("pre_rst_state", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_drain_ctl", ctl(), 32'(C_ZERO));
    step();
    chk("rst_drain_state", 32'(state), 32'd0);
    chk("rst_drain_stall", 32'(stall_cnt), 32'd0);
    chk("rst_drain_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    chk("post_rst_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the event counters.
REQ-002 The block SHALL have parameter DRAIN_LEN, default 4, setting the number of bubble-injection cycles before halt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 run  input  1  pipeline enable; 1 = execute, 0 = drain then halt.
REQ-006 id_rs  input  5  IF/ID instruction bits [25:21].
REQ-007 id_rt  input  5  IF/ID instruction bits [20:16].
REQ-008 id_uses_rt  input  1  the ID-stage instruction reads rt (R-type, store, branch).
REQ-009 ex_mem_read  input  1  ID/EX MemRead.
REQ-010 ex_rt  input  5  ID/EX Ins[20:16], the load destination.
REQ-011 mem_branch_taken  input  1  EX/MEM Branch AND EX/MEM Zflag.
REQ-012 pc_we  output  1  PC register load enable.
REQ-013 pc_src  output  1  PC mux select; 1 = EX/MEM branch target.
REQ-014 ifid_we  output  1  IF/ID load enable.
REQ-015 ifid_flush  output  1  IF/ID load a bubble (all zero).
REQ-016 idex_flush  output  1  ID/EX control bits load zero.
REQ-017 exmem_flush  output  1  EX/MEM control bits load zero.
REQ-018 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 HALTED.
REQ-019 halted  output  1  high only in HALTED.
REQ-020 stall_cnt  output  CNT_W  load-use stall cycles, saturating.
REQ-021 flush_cnt  output  CNT_W  taken-branch flush events, saturating.

Function
REQ-022 Define hazard = ex_mem_read and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
REQ-023 Define taken = mem_branch_taken while state is RUN or DRAIN; taken SHALL be 0 in IDLE and HALTED.
REQ-024 All control outputs SHALL be combinational (Mealy) from the current state and current inputs; FSM state and counters SHALL be registered.
REQ-025 In IDLE, all control outputs SHALL be 0; the block SHALL move to RUN on the next edge when run=1.
REQ-026 In RUN with no event, the block SHALL drive pc_we=1 and ifid_we=1, with all flush outputs 0.
REQ-027 On taken (priority over hazard), the block SHALL drive pc_we=1, pc_src=1, ifid_we=1, ifid_flush=1, idex_flush=1, exmem_flush=1, and increment flush_cnt; no stall SHALL be counted that cycle.
REQ-028 On hazard without taken, the block SHALL drive pc_we=0, ifid_we=0, idex_flush=1, and increment stall_cnt; the stall SHALL last exactly 1 cycle per detected hazard.
REQ-029 In RUN, when run=0, the block SHALL enter DRAIN on the next edge and load drain_cnt=DRAIN_LEN; a same-cycle taken or hazard SHALL still be serviced that cycle.
REQ-030 In DRAIN with no event, the block SHALL drive pc_we=0, ifid_we=1, ifid_flush=1 and decrement drain_cnt; it SHALL enter HALTED at the edge where drain_cnt goes 1->0.
REQ-031 In DRAIN with hazard, the REQ-028 outputs SHALL apply, ifid_flush SHALL be 0, and drain_cnt SHALL hold.
REQ-032 In DRAIN with taken, the REQ-027 outputs SHALL apply, PC SHALL hold the target for resumption, and drain_cnt SHALL reload to DRAIN_LEN.
REQ-033 In DRAIN, run=1 SHALL NOT abort the drain; the sequence SHALL complete to HALTED.
REQ-034 In HALTED, the block SHALL drive halted=1 with all control outputs 0; it SHALL move to RUN on the next edge when run=1.
REQ-035 Counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-036 When rst=1 at an edge, the block SHALL set state=IDLE, drain_cnt=0, stall_cnt=0, flush_cnt=0, overriding all other inputs in any state, including mid-DRAIN.
REQ-037 While rst=1, the registered outputs (state, halted, counters) SHALL show their reset values from the first edge; control outputs SHALL follow IDLE.

Verification
REQ-038 Reset then run=1: state goes IDLE->RUN after 1 edge; pc_we=ifid_we=1; counters 0.
REQ-039 RUN with ex_mem_read=1, ex_rt=5, id_rs=5: exactly one cycle of pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1. Repeat with ex_rt=0: no stall.
REQ-040 Hazard and mem_branch_taken=1 in the same cycle: all flushes=1, pc_src=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
REQ-041 run=0 in RUN: 4 DRAIN cycles with ifid_flush=1, then HALTED, halted=1; one hazard inserted mid-drain stretches the drain to 5 cycles.
REQ-042 Preload stall_cnt to 2^CNT_W-1 (or CNT_W=2, 4 hazards): the count holds at 3; rst=1 during DRAIN gives state=0 and counters=0 on the next edge.
